// File: rtl/alu_operand_stage_pkg.sv
// Shared widths and the immediate-extension helper for the ALU operand-fetch stage.
package alu_operand_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;
    localparam int CTR_W    = 3;
    localparam int IMM_W    = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [CTR_W-1:0]  alu_ctr_t;
    typedef logic [IMM_W-1:0]  imm_t;

    function automatic data_t ext_imm(input imm_t imm, input logic sign_ext);
        logic fill;
        fill = sign_ext & imm[IMM_W-1];
        return {{(DATA_W-IMM_W){fill}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue, ALU-facing and write-back signals of the operand stage bundled as one interface.
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd_in;
    imm_t      imm;
    logic      use_imm;
    logic      sign_ext;
    alu_ctr_t  alu_ctr_in;
    logic      wr_en_in;
    logic      flush;

    logic      out_valid;
    logic      out_ready;
    data_t     A;
    data_t     B;
    alu_ctr_t  ALUctr;
    reg_addr_t rd_out;
    logic      reg_wr_out;

    logic      wb_en;
    reg_addr_t wb_addr;
    data_t     wb_data;

    modport master (
        output in_valid, rs, rt, rd_in, imm, use_imm, sign_ext, alu_ctr_in, wr_en_in, flush,
        output out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, A, B, ALUctr, rd_out, reg_wr_out
    );

    modport slave (
        input  in_valid, rs, rt, rd_in, imm, use_imm, sign_ext, alu_ctr_in, wr_en_in, flush,
        input  out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, A, B, ALUctr, rd_out, reg_wr_out
    );

endinterface

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// 32x32 register file: two combinational read ports with write-back bypass, one write port, R0 hardwired to zero.
module regfile_2r1w
    import alu_operand_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t ra_a_i,
    input  reg_addr_t ra_b_i,
    output data_t     rd_a_o,
    output data_t     rd_b_o,
    input  logic      we_i,
    input  reg_addr_t wa_i,
    input  data_t     wd_i
);

    data_t mem_q [NUM_REGS];

    // NOTE: the storage itself is reset because the architecture defines every register as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // A write landing this cycle is forwarded so the issuing instruction sees the new value.
    always_comb begin
        rd_a_o = '0;
        rd_b_o = '0;
        if (ra_a_i != '0) rd_a_o = (we_i && wa_i == ra_a_i) ? wd_i : mem_q[ra_a_i];
        if (ra_b_i != '0) rd_b_o = (we_i && wa_i == ra_b_i) ? wd_i : mem_q[ra_b_i];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register read, B-operand select, pending-write scoreboard and the valid/ready register feeding the ALU.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stage_if.slave   bus
);

    data_t                 rf_a;
    data_t                 rf_b;
    data_t                 b_sel;
    logic [NUM_REGS-1:0]   busy;
    logic                  hazard;
    logic                  accept;

    logic                  out_valid_q, out_valid_d;
    data_t                 a_q, a_d;
    data_t                 b_q, b_d;
    alu_ctr_t              ctr_q, ctr_d;
    reg_addr_t             rd_q, rd_d;
    logic                  reg_wr_q, reg_wr_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra_a_i (bus.rs),
        .ra_b_i (bus.rt),
        .rd_a_o (rf_a),
        .rd_b_o (rf_b),
        .we_i   (bus.wb_en),
        .wa_i   (bus.wb_addr),
        .wd_i   (bus.wb_data)
    );

    assign b_sel = bus.use_imm ? ext_imm(bus.imm, bus.sign_ext) : rf_b;

    // A write-back arriving this cycle already frees its register for issue.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = pend_q[r] && !(bus.wb_en && bus.wb_addr == REG_AW'(r));
        end
    end

    assign hazard = busy[bus.rs]
                  || (!bus.use_imm && busy[bus.rt])
                  || (bus.wr_en_in && busy[bus.rd_in]);

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        ctr_d       = ctr_q;
        rd_d        = rd_q;
        reg_wr_d    = reg_wr_q;
        pend_d      = pend_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            a_d         = rf_a;
            b_d         = b_sel;
            ctr_d       = bus.alu_ctr_in;
            rd_d        = bus.rd_in;
            reg_wr_d    = bus.wr_en_in;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clears first, set last, so a same-cycle set of the same register wins.
        if (bus.wb_en) pend_d[bus.wb_addr] = 1'b0;
        if (bus.flush && out_valid_q && reg_wr_q) pend_d[rd_q] = 1'b0;
        if (accept && bus.wr_en_in && bus.rd_in != '0) pend_d[bus.rd_in] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // NOTE: state is written with non-blocking assignments only; next-state values come from the comb block above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ctr_q       <= '0;
            rd_q        <= '0;
            reg_wr_q    <= 1'b0;
            pend_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctr_q       <= ctr_d;
            rd_q        <= rd_d;
            reg_wr_q    <= reg_wr_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.ALUctr     = ctr_q;
    assign bus.rd_out     = rd_q;
    assign bus.reg_wr_out = reg_wr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: hand-computed expectations checked with immediate assertions.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input reg_addr_t rs, input reg_addr_t rt, input logic use_imm,
                         input imm_t imm, input logic sext, input alu_ctr_t ctr,
                         input logic wr_en, input reg_addr_t rd);
        bus.in_valid   = 1'b1;
        bus.rs         = rs;
        bus.rt         = rt;
        bus.use_imm    = use_imm;
        bus.imm        = imm;
        bus.sign_ext   = sext;
        bus.alu_ctr_in = ctr;
        bus.wr_en_in   = wr_en;
        bus.rd_in      = rd;
    endtask

    task automatic wb(input logic en, input reg_addr_t addr, input data_t data);
        bus.wb_en   = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.rs         = '0;
        bus.rt         = '0;
        bus.rd_in      = '0;
        bus.imm        = '0;
        bus.use_imm    = 1'b0;
        bus.sign_ext   = 1'b0;
        bus.alu_ctr_in = '0;
        bus.wr_en_in   = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        wb(1'b0, '0, '0);

        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_A", bus.A, 32'h0);
        check("rst_B", bus.B, 32'h0);
        check("rst_ALUctr", 32'(bus.ALUctr), 32'h0);
        check("rst_rd_out", 32'(bus.rd_out), 32'h0);
        check("rst_reg_wr_out", 32'(bus.reg_wr_out), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write-back R1 and R2, then read both.
        wb(1'b1, 5'd1, 32'h0000_0005);
        tick();
        wb(1'b1, 5'd2, 32'hFFFF_FFFF);
        tick();
        wb(1'b0, '0, '0);
        issue(5'd1, 5'd2, 1'b0, 16'h0, 1'b0, 3'b010, 1'b0, 5'd0);
        #1;
        check("basic_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("basic_out_valid", 32'(bus.out_valid), 32'h1);
        check("basic_A", bus.A, 32'h0000_0005);
        check("basic_B", bus.B, 32'hFFFF_FFFF);
        check("basic_ALUctr", 32'(bus.ALUctr), 32'h2);

        // Immediate extension, back to back.
        issue(5'd0, 5'd0, 1'b1, 16'h8000, 1'b1, 3'b011, 1'b0, 5'd0);
        tick();
        check("sext_B", bus.B, 32'hFFFF_8000);
        check("sext_A", bus.A, 32'h0);
        issue(5'd0, 5'd0, 1'b1, 16'h8000, 1'b0, 3'b011, 1'b0, 5'd0);
        tick();
        check("zext_B", bus.B, 32'h0000_8000);
        check("zext_valid", 32'(bus.out_valid), 32'h1);

        // Same-cycle write-back bypass.
        issue(5'd3, 5'd0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        wb(1'b1, 5'd3, 32'h0000_1234);
        tick();
        check("bypass_A", bus.A, 32'h0000_1234);
        check("bypass_B", bus.B, 32'h0);

        // Writes to R0 are ignored, including via the bypass path.
        issue(5'd0, 5'd0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        check("r0_bypass_A", bus.A, 32'h0);
        wb(1'b0, '0, '0);
        tick();
        check("r0_read_A", bus.A, 32'h0);
        check("r0_read_B", bus.B, 32'h0);

        // RAW hazard on R4.
        issue(5'd1, 5'd2, 1'b0, 16'h0, 1'b0, 3'b001, 1'b1, 5'd4);
        tick();
        check("raw_rd_out", 32'(bus.rd_out), 32'h4);
        check("raw_reg_wr", 32'(bus.reg_wr_out), 32'h1);
        issue(5'd4, 5'd0, 1'b0, 16'h0, 1'b0, 3'b100, 1'b0, 5'd0);
        #1;
        check("raw_stall0", 32'(bus.in_ready), 32'h0);
        tick();
        check("raw_drained", 32'(bus.out_valid), 32'h0);
        check("raw_stall1", 32'(bus.in_ready), 32'h0);
        wb(1'b1, 5'd4, 32'h0000_CAFE);
        #1;
        check("raw_release", 32'(bus.in_ready), 32'h1);
        tick();
        wb(1'b0, '0, '0);
        check("raw_A", bus.A, 32'h0000_CAFE);
        check("raw_valid", 32'(bus.out_valid), 32'h1);
        check("raw_ALUctr", 32'(bus.ALUctr), 32'h4);

        // WAW hazard on R4; set wins over a same-cycle clear.
        issue(5'd0, 5'd0, 1'b1, 16'h0001, 1'b0, 3'b000, 1'b1, 5'd4);
        tick();
        #1;
        check("waw_stall", 32'(bus.in_ready), 32'h0);
        wb(1'b1, 5'd4, 32'h0000_0007);
        #1;
        check("waw_release", 32'(bus.in_ready), 32'h1);
        tick();
        wb(1'b0, '0, '0);
        check("waw_rd_out", 32'(bus.rd_out), 32'h4);
        check("waw_B", bus.B, 32'h0000_0001);
        issue(5'd4, 5'd0, 1'b1, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        #1;
        check("waw_set_wins", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        wb(1'b1, 5'd4, 32'h0000_0009);
        tick();
        wb(1'b0, '0, '0);

        // Backpressure hold.
        issue(5'd1, 5'd0, 1'b1, 16'h0011, 1'b0, 3'b001, 1'b0, 5'd0);
        tick();
        bus.out_ready = 1'b0;
        issue(5'd2, 5'd1, 1'b0, 16'h0, 1'b0, 3'b110, 1'b1, 5'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_in_ready", 32'(bus.in_ready), 32'h0);
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'h1);
            check("hold_A", bus.A, 32'h0000_0005);
            check("hold_B", bus.B, 32'h0000_0011);
            check("hold_ALUctr", 32'(bus.ALUctr), 32'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("hold_release", 32'(bus.in_ready), 32'h1);
        tick();
        check("hold_next_A", bus.A, 32'hFFFF_FFFF);
        check("hold_next_B", bus.B, 32'h0000_0005);
        check("hold_next_ALUctr", 32'(bus.ALUctr), 32'h6);
        check("hold_next_rd", 32'(bus.rd_out), 32'h5);

        // Flush a held entry that owns pend[5].
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tick();
        check("flush_held", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        issue(5'd5, 5'd0, 1'b1, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        #1;
        check("flush_pend_set", 32'(bus.in_ready), 32'h0);
        bus.flush = 1'b1;
        #1;
        check("flush_blocks", 32'(bus.in_ready), 32'h0);
        tick();
        bus.flush = 1'b0;
        check("flush_valid", 32'(bus.out_valid), 32'h0);
        #1;
        check("flush_pend_clr", 32'(bus.in_ready), 32'h1);
        tick();
        check("flush_reissue", 32'(bus.out_valid), 32'h1);
        check("flush_reissue_A", bus.A, 32'h0);

        // Asynchronous reset mid-stream.
        issue(5'd1, 5'd2, 1'b0, 16'h0, 1'b0, 3'b111, 1'b1, 5'd7);
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_A", bus.A, 32'h0);
        check("arst_B", bus.B, 32'h0);
        check("arst_ALUctr", 32'(bus.ALUctr), 32'h0);
        check("arst_rd_out", 32'(bus.rd_out), 32'h0);
        check("arst_reg_wr", 32'(bus.reg_wr_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd7, 5'd1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0);
        #1;
        check("arst_pend_clr", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        check("arst_regs_A", bus.A, 32'h0);
        check("arst_regs_B", bus.B, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
